// File: rtl/multicycle_alu.sv
// Handshaked ALU: add/sub/logic in one cycle, shifts and rotates one bit per cycle.
// Latency: 1 edge for single-cycle and reserved ops, 1 + shamt edges for shifts/rotates.
// Backpressure: result is held in HOLD until out_ready; in_ready is low while shifting.
module multicycle_alu #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             err,
  output logic             busy
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_ASR = 4'd8;
  localparam logic [3:0] OP_ROR = 4'd9;
  localparam logic [3:0] OP_ROL = 4'd10;

  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD} state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_result;
  logic             r_z;
  logic             r_n;
  logic             r_c;
  logic             r_v;
  logic             r_err;
  logic [WIDTH-1:0] r_work;
  logic [SHW-1:0]   r_cnt;
  logic [3:0]       r_shop;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_shift_done;
  logic             w_is_shift;
  logic             w_start_shift;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_c;
  logic             w_alu_v;
  logic             w_alu_err;
  logic [WIDTH-1:0] w_step_res;
  logic             w_step_c;

  assign w_is_shift    = (op >= OP_SHL) && (op <= OP_ROL);
  // A zero-amount shift is just a pass-through of a, so it takes the single-cycle path.
  assign w_start_shift = w_is_shift && (shamt != '0);

  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next state and handshake: HOLD can hand off straight into a new op with no bubble.
  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_shift_done = 1'b0;
    case (r_state)
      S_IDLE:  w_in_ready = 1'b1;
      S_SHIFT: begin
        if (r_cnt == SHW'(1)) begin
          w_shift_done = 1'b1;
          w_next_state = S_HOLD;
        end
      end
      S_HOLD: begin
        w_in_ready = out_ready;
        if (out_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
    w_accept = in_valid & w_in_ready;
    if (w_accept) w_next_state = w_start_shift ? S_SHIFT : S_HOLD;
  end

  // Single-cycle result and carry/overflow for ops finishing on the accepting edge.
  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    w_alu_err = 1'b0;
    case (op)
      OP_ADD: begin
        w_alu_res = w_sum[MSB:0];
        w_alu_c   = w_sum[WIDTH];
        w_alu_v   = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        w_alu_res = w_diff[MSB:0];
        w_alu_c   = w_diff[WIDTH];
        w_alu_v   = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
      end
      OP_AND: w_alu_res = a & b;
      OP_OR:  w_alu_res = a | b;
      OP_XOR: w_alu_res = a ^ b;
      OP_NOT: w_alu_res = ~a;
      OP_SHL, OP_SHR, OP_ASR, OP_ROR, OP_ROL: w_alu_res = a;
      default: w_alu_err = 1'b1;
    endcase
  end

  // One-position shift/rotate of the working register; carry is the bit leaving it.
  always_comb begin
    w_step_res = r_work;
    w_step_c   = 1'b0;
    case (r_shop)
      OP_SHL: begin
        w_step_res = {r_work[MSB-1:0], 1'b0};
        w_step_c   = r_work[MSB];
      end
      OP_SHR: begin
        w_step_res = {1'b0, r_work[MSB:1]};
        w_step_c   = r_work[0];
      end
      OP_ASR: begin
        w_step_res = {r_work[MSB], r_work[MSB:1]};
        w_step_c   = r_work[0];
      end
      OP_ROR: begin
        w_step_res = {r_work[0], r_work[MSB:1]};
        w_step_c   = r_work[0];
      end
      OP_ROL: begin
        w_step_res = {r_work[MSB-1:0], r_work[MSB]};
        w_step_c   = r_work[MSB];
      end
      default: begin
        w_step_res = r_work;
        w_step_c   = 1'b0;
      end
    endcase
  end

  // Datapath: result/flags only change on the edge that enters HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
      r_err    <= 1'b0;
      r_work   <= '0;
      r_cnt    <= '0;
      r_shop   <= '0;
    end else if (w_accept) begin
      if (w_start_shift) begin
        r_work <= a;
        r_cnt  <= shamt;
        r_shop <= op;
      end else begin
        r_result <= w_alu_res;
        r_z      <= (w_alu_res == '0);
        r_n      <= w_alu_res[MSB];
        r_c      <= w_alu_c;
        r_v      <= w_alu_v;
        r_err    <= w_alu_err;
      end
    end else if (r_state == S_SHIFT) begin
      r_work <= w_step_res;
      r_cnt  <= r_cnt - SHW'(1);
      if (w_shift_done) begin
        r_result <= w_step_res;
        r_z      <= (w_step_res == '0);
        r_n      <= w_step_res[MSB];
        r_c      <= w_step_c;
        r_v      <= 1'b0;
        r_err    <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = (r_state == S_HOLD);
  assign busy      = (r_state == S_SHIFT);
  assign result    = r_result;
  assign flag_z    = r_z;
  assign flag_n    = r_n;
  assign flag_c    = r_c;
  assign flag_v    = r_v;
  assign err       = r_err;

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: random and directed ops against an arithmetic model.
// Latency: checked per result from the accepting edge to first out_valid.
// Backpressure: out_ready is randomized or held low to exercise HOLD and in_ready.
module tb_multicycle_alu;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   shamt;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         flag_z;
  logic         flag_n;
  logic         flag_c;
  logic         flag_v;
  logic         err;
  logic         busy;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
    .err(err), .busy(busy)
  );

  typedef struct {
    int res;
    int z, n, c, v, e;
    int acc;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   rand_or = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  // Reference model: plain integer arithmetic on the operation's definition.
  function automatic exp_t model(input int o, input int av, input int bv, input int s);
    exp_t e;
    int t;
    e.res = 0; e.c = 0; e.v = 0; e.e = 0;
    case (o)
      0: begin t = av + bv; e.res = t % 256; e.c = t / 256;
               t = sx(av) + sx(bv); e.v = (t > 127 || t < -128) ? 1 : 0; end
      1: begin t = av + (255 - bv) + 1; e.res = t % 256; e.c = t / 256;
               t = sx(av) - sx(bv); e.v = (t > 127 || t < -128) ? 1 : 0; end
      2: e.res = av & bv;
      3: e.res = av | bv;
      4: e.res = av ^ bv;
      5: e.res = 255 - av;
      6: begin e.res = (av << s) % 256; e.c = (s > 0) ? (av >> (8 - s)) & 1 : 0; end
      7: begin e.res = av >> s; e.c = (s > 0) ? (av >> (s - 1)) & 1 : 0; end
      8: begin e.res = (sx(av) >>> s) & 255; e.c = (s > 0) ? (av >> (s - 1)) & 1 : 0; end
      9: begin e.res = ((av >> s) | (av << (8 - s))) & 255;
               e.c = (s > 0) ? (av >> (s - 1)) & 1 : 0; end
      10: begin e.res = ((av << s) | (av >> (8 - s))) & 255;
                e.c = (s > 0) ? (av >> (8 - s)) & 1 : 0; end
      default: e.e = 1;
    endcase
    e.z = (e.res == 0) ? 1 : 0;
    e.n = (e.res >= 128) ? 1 : 0;
    e.lat = (o >= 6 && o <= 10 && s > 0) ? 1 + s : 1;
    e.acc = 0;
    return e;
  endfunction

  // Present one op; returns on the falling edge after it is accepted.
  task automatic issue(input int o, input int av, input int bv, input int s);
    exp_t e;
    int   n;
    op = o[3:0]; a = av[7:0]; b = bv[7:0]; shamt = s[2:0];
    in_valid = 1'b1;
    if (rand_or) out_ready = ($urandom_range(0, 3) != 0);
    #1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      if (rand_or) out_ready = ($urandom_range(0, 3) != 0);
      #1;
      n++;
    end
    if (!in_ready) begin
      $display("FAIL accept_timeout op=%0d in_ready=%0d", o, in_ready);
      errors++;
      checks++;
    end else begin
      e = model(o, av, bv, s);
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while ((sb.size() != 0 || out_valid || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    #3;
    chk("drain_empty", sb.size(), 0);
    @(negedge clk);
  endtask

  // Monitor: compares every presented cycle against the head of the scoreboard.
  initial begin
    exp_t e;
    bit   fresh;
    fresh = 1;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        fresh = 1;
      end else if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output result=0x%0h err=%0d", result, err);
        end else begin
          e = sb[0];
          chk("result", int'(result), e.res);
          chk("flags_zncv_err", {27'd0, flag_z, flag_n, flag_c, flag_v, err},
              (e.z << 4) | (e.n << 3) | (e.c << 2) | (e.v << 1) | e.e);
          if (fresh) begin
            fresh = 0;
            chk("latency", cyc - e.acc + 1, e.lat);
          end
          if (out_ready) begin
            void'(sb.pop_front());
            fresh = 1;
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; shamt = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_result", int'(result), 0);
    chk("reset_flags", {27'd0, flag_z, flag_n, flag_c, flag_v, err}, 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_in_ready", int'(in_ready), 1);
    @(negedge clk);

    // Arithmetic corners.
    issue(0, 8'hFF, 8'h01, 0);
    issue(1, 8'h80, 8'h01, 0);
    issue(1, 8'h01, 8'h02, 0);
    drain();

    // ASR by 4: busy and in_ready low for exactly 4 cycles.
    issue(8, 8'h90, 0, 4);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("asr_busy", int'(busy), 1);
      chk("asr_in_ready", int'(in_ready), 0);
      @(negedge clk);
    end
    #1;
    chk("asr_busy_done", int'(busy), 0);
    chk("asr_out_valid", int'(out_valid), 1);
    @(negedge clk);
    issue(9, 8'h81, 0, 3);
    drain();

    // Backpressure then zero-bubble handoff.
    out_ready = 1'b0;
    issue(4, 8'hA5, 8'h0F, 0);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    issue(2, 8'hF0, 8'h3C, 0);
    drain();

    // Reset during the third SHIFT cycle drops the operation.
    issue(6, 8'h5B, 0, 7);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_out_valid", int'(out_valid), 0);
    chk("rst_mid_result", int'(result), 0);
    chk("rst_mid_in_ready", int'(in_ready), 1);
    chk("rst_mid_busy", int'(busy), 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      chk("rst_mid_no_stale", int'(out_valid), 0);
    end
    @(negedge clk);

    // Reserved op, then zero-amount rotate.
    issue(15, 8'h3C, 8'h77, 0);
    issue(10, 8'h81, 0, 0);
    drain();

    // Randomized traffic with random backpressure.
    rand_or = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
      end
      issue($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 7));
    end
    rand_or = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Parametrised, handshaked ALU that succeeds the combinational adder, logic and shifter units. It covers arithmetic, logic and variable-amount shift/rotate operations and produces a registered result with status flags. Single-cycle ops complete in one cycle. Shifts and rotates run iteratively, one bit position per cycle, so no barrel shifter is needed. It sits between an operand-issue stage and a writeback stage, using valid/ready handshakes on both sides.

## Interface
- `WIDTH`, 8: datapath width; power of two, ≥ 4.
- `SHW`, $clog2(WIDTH): localparam, shift-amount width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: operand/op presented.
- `in_ready` out 1: block can accept; transfer when `in_valid & in_ready` at an edge.
- `op` in 4: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 SHL, 7 SHR (logical), 8 ASR, 9 ROR, 10 ROL; 11–15 reserved.
- `a`, `b` in WIDTH: operands; shifts/rotates use `a` only.
- `shamt` in SHW: shift/rotate amount, 0..WIDTH-1.
- `out_valid` out 1: result/flags valid.
- `out_ready` in 1: consumer accepts; transfer when `out_valid & out_ready`.
- `result` out WIDTH: registered result.
- `flag_z`, `flag_n`, `flag_c`, `flag_v` out 1 each: zero, negative (result MSB), carry, signed overflow.
- `err` out 1: reserved op issued; qualified by `out_valid`.
- `busy` out 1: high in SHIFT state.

## Operation
- **FSM states**
  - IDLE: no result held.
  - SHIFT: iterating a shift/rotate.
  - HOLD: result held, `out_valid`=1.
- **`in_ready` rule:** `in_ready` = (IDLE) | (HOLD & `out_ready`). It is combinational from state and `out_ready`. It is low in SHIFT.
- **On accept**
  - Non-shift op, or shift/rotate with `shamt`=0: compute result and flags, register them, go to HOLD.
  - Shift/rotate with `shamt`>0: load `a` into the working register and `shamt` into the counter, go to SHIFT.
- **SHIFT state:** each cycle, shift or rotate by one position and capture the bit moved out into carry. Decrement the counter. When the counter reaches 0 after the update, go to HOLD.
- **Fill rules:** SHL fills with 0. SHR fills with 0. ASR replicates the MSB. ROR and ROL wrap around.
- **HOLD state**
  - `out_ready`=0: `result`, flags and `err` stay stable.
  - `out_ready`=1 with no new accept: go to IDLE.
  - `out_ready`=1 with a simultaneous accept: follow the accept rules, with no bubble.
- **Arithmetic**
  - ADD: WIDTH+1-bit sum; C = bit WIDTH.
  - SUB: a + ~b + 1; C = carry out, 1 meaning no borrow (a ≥ b unsigned).
  - V, for ADD and SUB: signed overflow of the two's-complement operation.
- **Flags for other ops**
  - Logic ops: C = 0, V = 0.
  - Shifts/rotates: C = last bit moved out, 0 if `shamt`=0; V = 0.
  - Z and N are always derived from the final `result`.
- **Reserved op:** `result`=0, `err`=1, Z=1, N=C=V=0. Latency is 1.
- **Reset**
  - State goes to IDLE, `out_valid`=0, `result`=0, all flags 0, `err`=0, `busy`=0, counter 0.
  - `in_ready`=1 after reset.
  - Reset during SHIFT or HOLD discards the operation. No result is ever presented for it.

## Timing
- **Latency** is counted as edges from the accepting edge (inclusive) to the first cycle with `out_valid`=1.
  - 1 for non-shift ops, reserved ops and `shamt`=0.
  - 1 + `shamt` for shifts/rotates.
- **Throughput:** 1 op/cycle for non-shift ops while `out_ready`=1.
- **Ready behaviour:** `in_ready` is low for exactly `shamt` cycles during a shift.
- **Output stability:** `result` and flags change only on the edge that loads HOLD.

## Test plan
- **Reset, then ADD:** ADD a=0xFF, b=0x01 -> `result`=0x00, Z=1, C=1, V=0, N=0. `out_valid` high the cycle after accept.
- **SUB overflow:** SUB a=0x80, b=0x01 -> 0x7F, C=1, V=1, N=0, Z=0.
  - Then SUB 0x01-0x02 -> 0xFF, C=0, N=1.
- **ASR timing:** ASR a=0x90, shamt=4 -> 0xF9, N=1, C=0.
  - `busy` and `in_ready`=0 for 4 cycles; `out_valid` after 5 edges.
  - Then ROR a=0x81, shamt=3 -> 0x30, C=0.
- **Backpressure:** XOR 0xA5^0x0F -> 0xAA held stable with `out_ready`=0 for 10 cycles, `in_ready`=0.
  - Raise `out_ready` with AND 0xF0&0x3C valid in the same cycle -> 0x30 presented on the next cycle, with no idle gap.
- **Reset mid-shift:** SHL shamt=7 accepted, `rst` asserted on the 3rd SHIFT cycle.
  - Next cycle: IDLE, `out_valid`=0, `result`=0, `in_ready`=1, no stale output.
- **Reserved op:** op=0xF -> `result`=0, `err`=1, Z=1, latency 1.
  - Then ROL a=0x81, shamt=0 -> 0x81, C=0, latency 1.
